// File: rtl/conv_pkg.sv
// Shared definitions for the img2col streaming stage and the weight-side reorder logic:
// output-size derivation, FSM encoding and the patch element slice position.
package conv_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_EMIT = 2'd2
   } state_t;

   function automatic int out_dim(input int img, input int pad, input int k, input int stride);
      return (img + 2 * pad - k) / stride + 1;
   endfunction

   function automatic int patch_len(input int kh, input int kw, input int ch);
      return kh * kw * ch;
   endfunction

   // A counter that must reach max_val needs at least one bit even when max_val is 0
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

   function automatic int slice_msb(input int b, input int patch, input int bw);
      return patch * bw - 1 - b * bw;
   endfunction

endpackage

// File: rtl/conv2d_img2col_stream_gather.sv
// Combinational gather of one zero-padded convolution patch at output position (r,c)
// from the flattened frame buffer; element 0 lands in the patch MSBs.
module img2col_patch_gather
   import conv_pkg::*;
#(
   parameter int BITWIDTH = 8,
   parameter int IMG_H    = 28,
   parameter int IMG_W    = 28,
   parameter int CHANNELS = 1,
   parameter int K_H      = 3,
   parameter int K_W      = 3,
   parameter int PADDING  = 0,
   parameter int STRIDE   = 1,
   parameter int RW       = 5,
   parameter int CW       = 5,
   localparam int PATCH   = patch_len(K_H, K_W, CHANNELS),
   localparam int PW      = CHANNELS * BITWIDTH
)
(
   input  logic [IMG_H*IMG_W-1:0][PW-1:0] frame,
   input  logic [RW-1:0]                  r,
   input  logic [CW-1:0]                  c,
   output logic [PATCH*BITWIDTH-1:0]      patch
);

   // Signed coordinates one bit wider than the padded extent so negative rows/cols stay negative
   localparam int YW  = cnt_width(IMG_H + 2 * PADDING) + 1;
   localparam int XW  = cnt_width(IMG_W + 2 * PADDING) + 1;
   localparam int IXW = cnt_width(IMG_H * IMG_W - 1);

   typedef logic signed [YW-1:0] ycoord_t;
   typedef logic signed [XW-1:0] xcoord_t;

   // Walk the kernel window, substituting zero outside the image
   always_comb begin : gather
      ycoord_t        y;
      xcoord_t        x;
      logic [PW-1:0]  pix;
      y     = '0;
      x     = '0;
      pix   = '0;
      patch = '0;
      for (int p = 0; p < K_H; p++) begin
         for (int q = 0; q < K_W; q++) begin
            y = ycoord_t'(int'(r) * STRIDE + p - PADDING);
            x = xcoord_t'(int'(c) * STRIDE + q - PADDING);
            if ((y >= ycoord_t'(0)) && (y < ycoord_t'(IMG_H)) &&
                (x >= xcoord_t'(0)) && (x < xcoord_t'(IMG_W))) begin
               pix = frame[IXW'(int'(y) * IMG_W + int'(x))];
            end else begin
               pix = '0;
            end
            for (int ch = 0; ch < CHANNELS; ch++) begin
               patch[slice_msb(((p * K_W) + q) * CHANNELS + ch, PATCH, BITWIDTH) -: BITWIDTH] =
                  pix[(CHANNELS - 1 - ch) * BITWIDTH +: BITWIDTH];
            end
         end
      end
   end

endmodule

// File: rtl/conv2d_img2col_stream.sv
// Streaming img2col: buffers one raster-order frame, then emits one flattened padded/strided
// patch per output handshake, with out_last marking the final patch of the frame.
module conv2d_img2col_stream
   import conv_pkg::*;
#(
   parameter int BITWIDTH = 8,
   parameter int IMG_H    = 28,
   parameter int IMG_W    = 28,
   parameter int CHANNELS = 1,
   parameter int K_H      = 3,
   parameter int K_W      = 3,
   parameter int PADDING  = 0,
   parameter int STRIDE   = 1,
   localparam int OUT_H   = out_dim(IMG_H, PADDING, K_H, STRIDE),
   localparam int OUT_W   = out_dim(IMG_W, PADDING, K_W, STRIDE),
   localparam int PATCH   = patch_len(K_H, K_W, CHANNELS)
)
(
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [CHANNELS*BITWIDTH-1:0] in_pixel,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [PATCH*BITWIDTH-1:0]    out_patch,
   output logic                         out_last,
   output logic                         busy
);

   localparam int   PW        = CHANNELS * BITWIDTH;
   localparam int   NPIX      = IMG_H * IMG_W;
   localparam int   RW        = cnt_width(IMG_H - 1);
   localparam int   CW        = cnt_width(IMG_W - 1);
   localparam int   ORW       = cnt_width(OUT_H - 1);
   localparam int   OCW       = cnt_width(OUT_W - 1);
   localparam int   IXW       = cnt_width(NPIX - 1);
   localparam logic ONE_PATCH = (OUT_H == 1) && (OUT_W == 1);

   state_t                    state_r;
   logic [RW-1:0]             row_r;
   logic [CW-1:0]             col_r;
   logic [ORW-1:0]            orow_r;
   logic [OCW-1:0]            ocol_r;
   logic [NPIX-1:0][PW-1:0]   frame_r;
   logic [NPIX-1:0][PW-1:0]   frame_s;

   logic                      accept_s;
   logic                      adv_s;
   logic                      col_wrap_s;
   logic                      last_pix_s;
   logic                      ocol_wrap_s;
   logic                      next_last_s;
   logic [IXW-1:0]            wr_idx_s;
   logic [ORW-1:0]            orow_nx_s;
   logic [OCW-1:0]            ocol_nx_s;
   logic [ORW-1:0]            gr_s;
   logic [OCW-1:0]            gc_s;
   logic [PATCH*BITWIDTH-1:0] patch_s;

   // Handshake decode, write address and next output coordinate
   always_comb begin
      accept_s    = in_valid & in_ready;
      adv_s       = out_valid & out_ready;
      col_wrap_s  = (col_r == CW'(IMG_W - 1));
      last_pix_s  = (row_r == RW'(IMG_H - 1)) && col_wrap_s;
      wr_idx_s    = IXW'(int'(row_r) * IMG_W + int'(col_r));
      ocol_wrap_s = (ocol_r == OCW'(OUT_W - 1));
      if (ocol_wrap_s) begin
         ocol_nx_s = '0;
         orow_nx_s = orow_r + ORW'(1);
      end else begin
         ocol_nx_s = ocol_r + OCW'(1);
         orow_nx_s = orow_r;
      end
      next_last_s = (orow_nx_s == ORW'(OUT_H - 1)) && (ocol_nx_s == OCW'(OUT_W - 1));
      // While loading, the gather prepares patch (0,0) so it is ready the cycle after the last pixel
      if (state_r == ST_EMIT) begin
         gr_s = orow_nx_s;
         gc_s = ocol_nx_s;
      end else begin
         gr_s = '0;
         gc_s = '0;
      end
   end

   // Forward the pixel being written this cycle so patch (0,0) sees the final pixel
   always_comb begin
      frame_s = frame_r;
      if (accept_s) begin
         frame_s[wr_idx_s] = in_pixel;
      end else begin
         frame_s = frame_r;
      end
   end

   // Frame buffer storage; contents are meaningless until a full frame is loaded
   always_ff @(posedge clk) begin
      if (accept_s) begin
         frame_r[wr_idx_s] <= in_pixel;
      end
   end

   img2col_patch_gather #(
      .BITWIDTH (BITWIDTH),
      .IMG_H    (IMG_H),
      .IMG_W    (IMG_W),
      .CHANNELS (CHANNELS),
      .K_H      (K_H),
      .K_W      (K_W),
      .PADDING  (PADDING),
      .STRIDE   (STRIDE),
      .RW       (ORW),
      .CW       (OCW)
   ) u_gather (
      .frame (frame_s),
      .r     (gr_s),
      .c     (gc_s),
      .patch (patch_s)
   );

   // Frame FSM with counters and registered stream outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= ST_IDLE;
         row_r     <= '0;
         col_r     <= '0;
         orow_r    <= '0;
         ocol_r    <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_patch <= '0;
         busy      <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE, ST_LOAD: begin
               if (accept_s) begin
                  busy <= 1'b1;
                  if (last_pix_s) begin
                     state_r   <= ST_EMIT;
                     row_r     <= '0;
                     col_r     <= '0;
                     orow_r    <= '0;
                     ocol_r    <= '0;
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                     out_patch <= patch_s;
                     out_last  <= ONE_PATCH;
                  end else begin
                     state_r <= ST_LOAD;
                     if (col_wrap_s) begin
                        col_r <= '0;
                        row_r <= row_r + RW'(1);
                     end else begin
                        col_r <= col_r + CW'(1);
                     end
                  end
               end
            end
            ST_EMIT: begin
               if (adv_s) begin
                  if (out_last) begin
                     state_r   <= ST_IDLE;
                     orow_r    <= '0;
                     ocol_r    <= '0;
                     in_ready  <= 1'b1;
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     out_patch <= '0;
                     busy      <= 1'b0;
                  end else begin
                     orow_r    <= orow_nx_s;
                     ocol_r    <= ocol_nx_s;
                     out_patch <= patch_s;
                     out_last  <= next_last_s;
                  end
               end
            end
            default: begin
               state_r   <= ST_IDLE;
               row_r     <= '0;
               col_r     <= '0;
               orow_r    <= '0;
               ocol_r    <= '0;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               out_last  <= 1'b0;
               out_patch <= '0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_conv2d_img2col_stream.sv
// Directed bench for conv2d_img2col_stream: four configurations (plain, padded, strided,
// two-channel) checked against hand-computed patches, plus back-pressure and mid-frame reset.
module tb_conv2d_img2col_stream;

   logic         clk;
   logic         rst_n;
   logic [3:0]   iv, ir, ov, ordy, ol, bsy;
   logic [7:0]   px_a, px_b, px_c;
   logic [15:0]  px_d;
   logic [71:0]  pt_a, pt_b, pt_c;
   logic [143:0] pt_d;

   logic [144:0] cap_a[$], cap_b[$], cap_c[$], cap_d[$];
   logic [71:0]  exp_a[4];

   int checks;
   int errors;

   conv2d_img2col_stream #(.BITWIDTH(8), .IMG_H(4), .IMG_W(4), .CHANNELS(1), .K_H(3), .K_W(3),
                           .PADDING(0), .STRIDE(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_pixel(px_a),
      .out_valid(ov[0]), .out_ready(ordy[0]), .out_patch(pt_a), .out_last(ol[0]), .busy(bsy[0]));

   conv2d_img2col_stream #(.BITWIDTH(8), .IMG_H(4), .IMG_W(4), .CHANNELS(1), .K_H(3), .K_W(3),
                           .PADDING(1), .STRIDE(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_pixel(px_b),
      .out_valid(ov[1]), .out_ready(ordy[1]), .out_patch(pt_b), .out_last(ol[1]), .busy(bsy[1]));

   conv2d_img2col_stream #(.BITWIDTH(8), .IMG_H(5), .IMG_W(5), .CHANNELS(1), .K_H(3), .K_W(3),
                           .PADDING(0), .STRIDE(2)) dut_c (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_pixel(px_c),
      .out_valid(ov[2]), .out_ready(ordy[2]), .out_patch(pt_c), .out_last(ol[2]), .busy(bsy[2]));

   conv2d_img2col_stream #(.BITWIDTH(8), .IMG_H(3), .IMG_W(3), .CHANNELS(2), .K_H(3), .K_W(3),
                           .PADDING(0), .STRIDE(1)) dut_d (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]), .in_pixel(px_d),
      .out_valid(ov[3]), .out_ready(ordy[3]), .out_patch(pt_d), .out_last(ol[3]), .busy(bsy[3]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Capture every accepted patch with its last flag in bit 144
   always @(posedge clk) if (ov[0] && ordy[0]) cap_a.push_back({ol[0], 72'd0, pt_a});
   always @(posedge clk) if (ov[1] && ordy[1]) cap_b.push_back({ol[1], 72'd0, pt_b});
   always @(posedge clk) if (ov[2] && ordy[2]) cap_c.push_back({ol[2], 72'd0, pt_c});
   always @(posedge clk) if (ov[3] && ordy[3]) cap_d.push_back({ol[3], pt_d});

   task automatic check_val(input string tag, input logic [159:0] got, input logic [159:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [71:0] add_base(input logic [71:0] v, input logic [7:0] b);
      logic [71:0] r;
      for (int i = 0; i < 9; i++) r[i*8 +: 8] = v[i*8 +: 8] + b;
      return r;
   endfunction

   // Stream pixels first..last (value base+k; two-channel instance uses {k,-k}), starting at a negedge
   task automatic send_range(input int inst, input int first, input int last, input int base);
      int g;
      for (int k = first; k <= last; k++) begin
         case (inst)
            0:       px_a = 8'(base + k);
            1:       px_b = 8'(base + k);
            2:       px_c = 8'(base + k);
            default: px_d = {8'(k), 8'(-k)};
         endcase
         iv[inst] = 1'b1;
         g = 0;
         while (!ir[inst] && g < 100) begin
            @(negedge clk);
            g++;
         end
         if (g >= 100) check_val("in_ready_timeout", 160'(ir[inst]), 160'(1));
         @(negedge clk);
      end
      iv[inst] = 1'b0;
   endtask

   task automatic wait_idle(input int inst);
      int g;
      g = 0;
      while (!(ir[inst] && !ov[inst]) && g < 300) begin
         @(negedge clk);
         g++;
      end
      if (g >= 300) check_val("idle_timeout", 160'(ir[inst]), 160'(1));
   endtask

   initial begin
      checks = 0;
      errors = 0;
      exp_a[0] = {8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11};
      exp_a[1] = {8'd2, 8'd3, 8'd4, 8'd6, 8'd7, 8'd8, 8'd10, 8'd11, 8'd12};
      exp_a[2] = {8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11, 8'd13, 8'd14, 8'd15};
      exp_a[3] = {8'd6, 8'd7, 8'd8, 8'd10, 8'd11, 8'd12, 8'd14, 8'd15, 8'd16};
      rst_n = 1'b0;
      iv    = 4'b0000;
      ordy  = 4'b1111;
      px_a  = 8'd0;
      px_b  = 8'd0;
      px_c  = 8'd0;
      px_d  = 16'd0;
      repeat (2) @(negedge clk);
      check_val("rst_out_valid", 160'(ov), 160'(4'b0000));
      check_val("rst_in_ready", 160'(ir), 160'(4'b1111));
      check_val("rst_out_last", 160'(ol), 160'(4'b0000));
      check_val("rst_busy", 160'(bsy), 160'(4'b0000));
      check_val("rst_patch_a", 160'(pt_a), 160'(0));
      check_val("rst_patch_d", 160'(pt_d), 160'(0));
      rst_n = 1'b1;
      @(negedge clk);

      // Plain 4x4, K=3: latency and all four patches
      send_range(0, 1, 15, 0);
      check_val("a_valid_early", 160'(ov[0]), 160'(0));
      check_val("a_busy_load", 160'(bsy[0]), 160'(1));
      send_range(0, 16, 16, 0);
      check_val("a_valid_lat1", 160'(ov[0]), 160'(1));
      check_val("a_ready_low", 160'(ir[0]), 160'(0));
      check_val("a_first_patch", 160'(pt_a), 160'(exp_a[0]));
      wait_idle(0);
      check_val("a_count", 160'(cap_a.size()), 160'(4));
      for (int k = 0; k < 4; k++) begin
         check_val("a_patch", 160'(cap_a[k][71:0]), 160'(exp_a[k]));
         check_val("a_last", 160'(cap_a[k][144]), 160'(k == 3));
      end

      // Back-pressure mid-EMIT while in_valid stays high
      cap_a.delete();
      ordy[0] = 1'b0;
      send_range(0, 1, 16, 0);
      ordy[0] = 1'b1;
      @(negedge clk);
      ordy[0] = 1'b0;
      iv[0]   = 1'b1;
      px_a    = 8'hAA;
      repeat (5) begin
         @(negedge clk);
         check_val("stall_patch", 160'(pt_a), 160'(exp_a[1]));
         check_val("stall_valid", 160'(ov[0]), 160'(1));
         check_val("stall_in_ready", 160'(ir[0]), 160'(0));
      end
      iv[0]   = 1'b0;
      ordy[0] = 1'b1;
      wait_idle(0);
      check_val("stall_count", 160'(cap_a.size()), 160'(4));
      for (int k = 0; k < 4; k++) begin
         check_val("stall_seq", 160'(cap_a[k][71:0]), 160'(exp_a[k]));
         check_val("stall_last", 160'(cap_a[k][144]), 160'(k == 3));
      end
      cap_a.delete();
      send_range(0, 1, 16, 100);
      wait_idle(0);
      check_val("new_count", 160'(cap_a.size()), 160'(4));
      check_val("new_first", 160'(cap_a[0][71:0]), 160'(add_base(exp_a[0], 8'd100)));
      check_val("new_lastp", 160'(cap_a[3][71:0]), 160'(add_base(exp_a[3], 8'd100)));

      // Reset after 7 pixels, then a fresh frame must be the only data seen
      cap_a.delete();
      send_range(0, 1, 7, 200);
      check_val("part_busy", 160'(bsy[0]), 160'(1));
      rst_n = 1'b0;
      @(negedge clk);
      check_val("mid_rst_valid", 160'(ov[0]), 160'(0));
      check_val("mid_rst_patch", 160'(pt_a), 160'(0));
      check_val("mid_rst_ready", 160'(ir[0]), 160'(1));
      check_val("mid_rst_busy", 160'(bsy[0]), 160'(0));
      rst_n = 1'b1;
      @(negedge clk);
      send_range(0, 1, 16, 50);
      wait_idle(0);
      check_val("rst_frame_count", 160'(cap_a.size()), 160'(4));
      for (int k = 0; k < 4; k++) begin
         check_val("rst_frame_patch", 160'(cap_a[k][71:0]), 160'(add_base(exp_a[k], 8'd50)));
      end

      // Padding 1: sixteen patches, corners and an interior one
      send_range(1, 1, 16, 0);
      wait_idle(1);
      check_val("b_count", 160'(cap_b.size()), 160'(16));
      check_val("b_p00", 160'(cap_b[0][71:0]),
                160'({8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd0, 8'd5, 8'd6}));
      check_val("b_p03", 160'(cap_b[3][71:0]),
                160'({8'd0, 8'd0, 8'd0, 8'd3, 8'd4, 8'd0, 8'd7, 8'd8, 8'd0}));
      check_val("b_p11", 160'(cap_b[5][71:0]), 160'(exp_a[0]));
      check_val("b_p33", 160'(cap_b[15][71:0]),
                160'({8'd11, 8'd12, 8'd0, 8'd15, 8'd16, 8'd0, 8'd0, 8'd0, 8'd0}));
      check_val("b_last15", 160'(cap_b[15][144]), 160'(1));
      check_val("b_last14", 160'(cap_b[14][144]), 160'(0));

      // Stride 2 on 5x5
      send_range(2, 1, 25, 0);
      wait_idle(2);
      check_val("c_count", 160'(cap_c.size()), 160'(4));
      check_val("c_p01", 160'(cap_c[1][71:0]),
                160'({8'd3, 8'd4, 8'd5, 8'd8, 8'd9, 8'd10, 8'd13, 8'd14, 8'd15}));
      check_val("c_p11", 160'(cap_c[3][71:0]),
                160'({8'd13, 8'd14, 8'd15, 8'd18, 8'd19, 8'd20, 8'd23, 8'd24, 8'd25}));
      check_val("c_last", 160'(cap_c[3][144]), 160'(1));

      // Two channels, signed values interleaved per pixel
      send_range(3, 1, 9, 0);
      wait_idle(3);
      check_val("d_count", 160'(cap_d.size()), 160'(1));
      check_val("d_patch", 160'(cap_d[0][143:0]),
                160'({8'h01, 8'hFF, 8'h02, 8'hFE, 8'h03, 8'hFD, 8'h04, 8'hFC, 8'h05,
                      8'hFB, 8'h06, 8'hFA, 8'h07, 8'hF9, 8'h08, 8'hF8, 8'h09, 8'hF7}));
      check_val("d_last", 160'(cap_d[0][144]), 160'(1));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
